// File: rtl/fetch_pc_predictor_if.sv
// Fetch PC predictor bus: hazard/redirect/training inputs and fetch-side predictions.
// FETCH_PRED_PERF_EN adds the two performance counter outputs.
interface fetch_pc_predictor_if #(
  parameter int unsigned IDX_W = 6
) ();
  logic             StallF;
  logic             RedirectE;
  logic [31:0]      RedirectPCE;
  logic             UpdEnE;
  logic [31:0]      UpdPCE;
  logic             UpdTakenE;
  logic [31:0]      UpdTargetE;
  logic             UpdJalE;
  logic [31:0]      PCF;
  logic [31:0]      PCPlus4F;
  logic [IDX_W-1:0] PredIdxF;
  logic             PredTakenF;
  logic [31:0]      PredTargetF;
  logic             JalFlagF;
`ifdef FETCH_PRED_PERF_EN
  logic [31:0]      PerfRedirectCnt;
  logic [31:0]      PerfPredTakenCnt;
`endif

  // Driver side (pipeline / testbench)
  modport master (
    output StallF, RedirectE, RedirectPCE, UpdEnE, UpdPCE, UpdTakenE, UpdTargetE, UpdJalE,
    input  PCF, PCPlus4F, PredIdxF, PredTakenF, PredTargetF, JalFlagF
`ifdef FETCH_PRED_PERF_EN
    , input PerfRedirectCnt, PerfPredTakenCnt
`endif
  );

  // Predictor side
  modport slave (
    input  StallF, RedirectE, RedirectPCE, UpdEnE, UpdPCE, UpdTakenE, UpdTargetE, UpdJalE,
    output PCF, PCPlus4F, PredIdxF, PredTakenF, PredTargetF, JalFlagF
`ifdef FETCH_PRED_PERF_EN
    , output PerfRedirectCnt, PerfPredTakenCnt
`endif
  );
endinterface

// File: rtl/fetch_pc_predictor.sv
// Fetch-stage PC generator with a direct-mapped BTB and 2-bit direction counters.
// Optional macro FETCH_PRED_PERF_EN adds redirect / predicted-taken event counters.
module fetch_pc_predictor #(
  parameter int unsigned IDX_W    = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                  CLK,
  input logic                  RST,
  fetch_pc_predictor_if.slave  io_bus
);
  localparam int unsigned NumEnt = 2 ** IDX_W;
  localparam int unsigned TagW   = 30 - IDX_W;

  logic [31:0]      r_pc;
  logic             r_valid  [NumEnt];
  logic [TagW-1:0]  r_tag    [NumEnt];
  logic [31:0]      r_target [NumEnt];
  logic [1:0]       r_ctr    [NumEnt];
  logic             r_jal    [NumEnt];

  logic [IDX_W-1:0] w_fidx;
  logic [TagW-1:0]  w_ftag;
  logic             w_fhit;
  logic             w_pred_taken;
  logic [31:0]      w_pred_target;
  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_pc_next;
  logic [IDX_W-1:0] w_uidx;
  logic [TagW-1:0]  w_utag;
  logic             w_uhit;

  assign w_fidx = r_pc[IDX_W+1:2];
  assign w_ftag = r_pc[31:IDX_W+2];
  assign w_uidx = io_bus.UpdPCE[IDX_W+1:2];
  assign w_utag = io_bus.UpdPCE[31:IDX_W+2];

  // Lookup reads the current array contents, so a same-cycle update is seen next cycle
  always_comb begin
    w_fhit        = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
    w_pred_taken  = w_fhit && (r_jal[w_fidx] || r_ctr[w_fidx][1]);
    w_pred_target = w_pred_taken ? r_target[w_fidx] : 32'h0;
    w_pc_plus4    = r_pc + 32'd4;
    w_uhit        = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  end

  // Next-PC priority: redirect beats stall beats prediction beats sequential
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (io_bus.RedirectE)   w_pc_next = io_bus.RedirectPCE;
    else if (io_bus.StallF) w_pc_next = r_pc;
    else if (w_pred_taken)  w_pc_next = w_pred_target;
  end

  // Fetch PC register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_pc <= RESET_PC;
    else      r_pc <= w_pc_next;
  end

  // BTB training; not gated by stall
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NumEnt; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= 32'h0;
        r_ctr[i]    <= 2'b01;
        r_jal[i]    <= 1'b0;
      end
    end else if (io_bus.UpdEnE) begin
      if (w_uhit) begin
        if (io_bus.UpdTakenE) begin
          if (r_ctr[w_uidx] != 2'b11) r_ctr[w_uidx] <= r_ctr[w_uidx] + 2'd1;
          r_target[w_uidx] <= io_bus.UpdTargetE;
        end else if (r_ctr[w_uidx] != 2'b00) begin
          r_ctr[w_uidx] <= r_ctr[w_uidx] - 2'd1;
        end
        r_jal[w_uidx] <= io_bus.UpdJalE;
      end else if (io_bus.UpdTakenE) begin
        // Allocate weakly taken, evicting whatever occupied the slot
        r_valid[w_uidx]  <= 1'b1;
        r_tag[w_uidx]    <= w_utag;
        r_target[w_uidx] <= io_bus.UpdTargetE;
        r_ctr[w_uidx]    <= 2'b10;
        r_jal[w_uidx]    <= io_bus.UpdJalE;
      end
    end
  end

  assign io_bus.PCF         = r_pc;
  assign io_bus.PCPlus4F    = w_pc_plus4;
  assign io_bus.PredIdxF    = w_fidx;
  assign io_bus.PredTakenF  = w_pred_taken;
  assign io_bus.PredTargetF = w_pred_target;
  assign io_bus.JalFlagF    = w_fhit && r_jal[w_fidx];

`ifdef FETCH_PRED_PERF_EN
  logic [31:0] r_perf_redir;
  logic [31:0] r_perf_pt;

  // Event counters; predicted-taken only counts when the prediction actually steers fetch
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_perf_redir <= 32'h0;
      r_perf_pt    <= 32'h0;
    end else begin
      if (io_bus.RedirectE) r_perf_redir <= r_perf_redir + 32'd1;
      if (w_pred_taken && !io_bus.StallF && !io_bus.RedirectE) r_perf_pt <= r_perf_pt + 32'd1;
    end
  end

  assign io_bus.PerfRedirectCnt  = r_perf_redir;
  assign io_bus.PerfPredTakenCnt = r_perf_pt;
`endif
endmodule

// File: doc/fetch_pc_predictor.md
Name: fetch_pc_predictor

Overview:
Fetch-stage PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It produces the fetch PC, PC+4, the predicted-taken flag, the predicted target, the BTB index and the JAL flag. These feed the IF/ID pipeline register. Execute-stage resolution drives redirect on mispredict and trains the BTB.

Parameters:
- IDX_W, 6, BTB index width; BTB holds 2**IDX_W entries, index = PC[IDX_W+1:2].
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-low reset
- StallF  in  1  hold PC (hazard unit)
- RedirectE  in  1  mispredict; load RedirectPCE next cycle
- RedirectPCE  in  32  correct next PC from execute
- UpdEnE  in  1  resolved control-flow instruction in execute; train BTB
- UpdPCE  in  32  PC of the resolved instruction
- UpdTakenE  in  1  actual direction
- UpdTargetE  in  32  actual target
- UpdJalE  in  1  resolved instruction is JAL (unconditional)
- PCF  out  32  current fetch PC (instruction memory address)
- PCPlus4F  out  32  PCF+4
- PredIdxF  out  IDX_W  BTB index of PCF
- PredTakenF  out  1  predicted taken
- PredTargetF  out  32  predicted target (0 when not predicted taken)
- JalFlagF  out  1  BTB hit on a JAL entry

Behaviour:
- Reset (async, RST=0): PCF=RESET_PC; every entry valid=0, ctr=2'b01, jal=0, tag/target=0. PCF/PCPlus4F/PredIdxF follow PCF. PredTakenF=0, PredTargetF=0, JalFlagF=0 (no valid entries).
- Entry fields: valid, tag=PC[31:IDX_W+2], target[31:0], ctr[1:0], jal.
- Lookup (combinational on PCF): hit = valid && tag==PCF[31:IDX_W+2].
  - PredTakenF = hit && (jal || ctr[1]).
  - PredTargetF = PredTakenF ? target : 0.
  - JalFlagF = hit && jal.
  - PCPlus4F = PCF+4, mod 2^32; 32'hFFFF_FFFC wraps to 0.
- Next PC at each posedge, in priority order:
  1. RedirectE=1 -> RedirectPCE. Redirect overrides StallF.
  2. StallF=1 -> hold PCF.
  3. PredTakenF=1 -> PredTargetF.
  4. Otherwise -> PCPlus4F.
- Update at posedge when UpdEnE=1, at index i=UpdPCE[IDX_W+1:2]:
  - Tag hit: ctr saturating +1 if taken (max 2'b11), else -1 (min 2'b00). Target updated to UpdTargetE when taken; jal<=UpdJalE.
  - Miss and taken: allocate. valid=1, tag, target=UpdTargetE, ctr=2'b10 (weakly taken), jal=UpdJalE. Any existing entry is overwritten.
  - Miss and not taken: no change.
- Update is not gated by StallF.
- Update and lookup on the same index in the same cycle: lookup returns the pre-update contents (read-before-write). The new contents are visible from the next cycle.
- Single-cycle latency throughout; no internal FSM beyond PC register and BTB state.

Optional Feature:
- Macro: FETCH_PRED_PERF_EN.
- Defined: adds outputs PerfRedirectCnt[31:0] and PerfPredTakenCnt[31:0].
  - PerfRedirectCnt increments on each cycle with RedirectE=1.
  - PerfPredTakenCnt increments on each posedge where PredTakenF=1 and StallF=0 and RedirectE=0.
  - Both reset to 0 asynchronously and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset with RESET_PC=0, RST released, no stall, 4 cycles -> PCF 0,4,8,12; PredTakenF=0 throughout; PCPlus4F=PCF+4.
- UpdEnE with UpdPCE=0x40, taken, target 0x100, jal=0 -> next time PCF=0x40: PredTakenF=1, PredTargetF=0x100, PredIdxF=16, ctr=2'b10; following PCF=0x100.
- Train 0x40 not-taken twice after the allocation above -> ctr 10->01->00; fetch at 0x40 gives PredTakenF=0, next PCF=0x44. A third not-taken update keeps ctr=00.
- Alias 0x1040 (same index 16, different tag) after 0x40 allocated -> lookup at 0x1040 misses; a taken update at 0x1040 evicts 0x40, after which 0x40 misses.
- StallF=1 and RedirectE=1, RedirectPCE=0x200 in the same cycle -> PCF=0x200 next cycle. StallF=1 alone for 3 cycles -> PCF held.
- PCF=0xFFFF_FFFC with no prediction -> PCPlus4F=0, next PCF=0. JAL entry with ctr=00 -> PredTakenF=1, JalFlagF=1.
